lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial receiver-side counterpart to the 4-bit LFSR generator. Checks one received bit per DIN_VALID cycle against the generator's sequence.
- Self-synchronises by loading its state from received bits, then runs free on its own predictions (flywheel).
- Reports lock, per-bit errors, a saturating error count and loss-of-sync.
- Sits at the far end of an SRAM/link loopback path in the counter demo, fed by whatever sampled the generator's OUT.

Parameters:
- LOCK_LEN, 8, consecutive correct predictions in VERIFY required to declare lock (>=1).
- LOSS_ERRS, 4, consecutive mismatches in LOCKED that force resynchronisation (>=1).
- ERR_W, 8, width of ERR_CNT.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  1  received serial bit.
- DIN_VALID  input  1  DIN is a new bit this cycle; no action when low.
- CLR_CNT  input  1  synchronous clear of ERR_CNT.
- LOCKED  output  1  registered; high while in LOCKED state.
- BIT_ERR  output  1  registered one-cycle pulse; mismatch detected in LOCKED.
- SYNC_LOSS  output  1  registered one-cycle pulse; LOCKED->FILL transition.
- ERR_CNT  output  ERR_W  saturating count of LOCKED-state mismatches.

Behaviour:
- Sequence model, identical to the generator:
  - state R[3:0]; predicted bit p = R3^R2^R1^R0.
  - advance is R <= {bit, R[3:1]}.
  - recurrence b[n+4] = b[n+3]^b[n+2]^b[n+1]^b[n]; non-zero seeds give period 5.
- Reset (RST=1 at edge): state FILL, R=0, fill count=0, good count=0, bad count=0, LOCKED=0, BIT_ERR=0, SYNC_LOSS=0, ERR_CNT=0. RST overrides all other inputs in any state.
- Every state: when DIN_VALID=0, nothing changes and BIT_ERR/SYNC_LOSS are 0 next cycle.
- FILL, on each valid bit:
  - R <= {DIN, R[3:1]}; fill count increments, saturating at 4.
  - When the updated fill count is 4 and the updated R != 0, go to VERIFY with good count=0.
  - An all-zero window stays in FILL and keeps sliding.
- VERIFY, on each valid bit:
  - R <= {p, R[3:1]} (prediction, not DIN).
  - DIN==p: good count++. On reaching LOCK_LEN, go to LOCKED and set LOCKED=1 at that edge.
  - DIN!=p: go to FILL with fill count=0 and good count=0. No BIT_ERR, no ERR_CNT change.
- LOCKED, on each valid bit:
  - R <= {p, R[3:1]} (flywheel; errors never corrupt state).
  - DIN==p: bad count=0.
  - DIN!=p: BIT_ERR=1 next cycle, ERR_CNT++ (saturates at 2^ERR_W-1), bad count++.
  - When bad count reaches LOSS_ERRS: go to FILL, LOCKED=0, SYNC_LOSS=1 for one cycle, fill count=0. The final error is still counted.
- CLR_CNT=1: ERR_CNT <= 0 next cycle. This has priority over a simultaneous error, which is discarded; BIT_ERR still pulses.
- Latency:
  - With continuous valid bits from FILL, LOCKED rises at the edge of valid bit 4+LOCK_LEN (12 by default).
  - BIT_ERR and SYNC_LOSS follow the offending bit by one edge.
- Counter widths: fill 3 bits; good/bad sized by $clog2 of LOCK_LEN+1 and LOSS_ERRS+1.

Test Plan:
- Generator seed 4'b0001 gives stream 1,1,0,0,0 repeating; drive it with DIN_VALID=1 every cycle from reset release -> LOCKED=0 through bit 11, LOCKED=1 after bit 12, BIT_ERR never set, ERR_CNT=0.
- Locked, invert one bit -> exactly one BIT_ERR pulse, ERR_CNT=1, LOCKED stays 1, following correct bits produce no further errors (flywheel intact).
- Locked, invert 4 consecutive bits -> 4 BIT_ERR pulses, ERR_CNT=4, SYNC_LOSS pulse after the 4th, LOCKED=0. Clean stream continues and LOCKED returns 12 valid bits later.
- DIN constant 0 for 50 valid cycles -> remains in FILL, LOCKED=0, ERR_CNT=0. Also: a mismatch injected at VERIFY bit 5 -> no BIT_ERR, lock delayed to 4+8 bits after restart.
- ERR_W=2, 5 isolated errors while locked -> ERR_CNT saturates at 3. CLR_CNT in the same cycle as an error -> ERR_CNT=0, BIT_ERR=1.
- DIN_VALID toggled 1/0 alternately -> lock after 12 valid bits regardless of gaps. RST asserted while LOCKED -> next cycle LOCKED=0, ERR_CNT=0, pulses 0, resync from FILL.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// Serial bit stream into the LFSR checker plus its lock/error status back out.
// Pure wiring: no latency of its own.
// No backpressure: din_valid qualifies each bit and the checker always accepts it.
interface lfsr_checker_if #(
    parameter int ERR_W = 8
);
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             bit_err;
    logic             sync_loss;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, bit_err, sync_loss, err_cnt
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, bit_err, sync_loss, err_cnt
    );
endinterface

// File: rtl/lfsr_checker.sv
// Receiver-side checker for the 4-bit LFSR stream: self-syncs, flywheels, counts errors.
// Latency: status registered one edge after the bit; lock at valid bit 4+LOCK_LEN.
// No backpressure: every din_valid bit is consumed; idle cycles change nothing.
module lfsr_checker #(
    parameter int LOCK_LEN  = 8,
    parameter int LOSS_ERRS = 4,
    parameter int ERR_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);
    localparam int GOOD_W = $clog2(LOCK_LEN + 1);
    localparam int BAD_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]        state;
    logic [3:0]        r;
    logic [2:0]        fill_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;

    logic              pred;
    logic              match;
    logic [3:0]        r_fill;
    logic [3:0]        r_fly;
    logic [2:0]        fill_nxt;
    logic [ERR_W-1:0]  err_inc;

    always_comb begin
        pred     = ^r;
        match    = (bus.din == pred);
        r_fill   = {bus.din, r[3:1]};
        r_fly    = {pred, r[3:1]};
        fill_nxt = (fill_cnt == 3'd4) ? 3'd4 : fill_cnt + 3'd1;
        err_inc  = (&bus.err_cnt) ? bus.err_cnt : bus.err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FILL;
            r             <= 4'd0;
            fill_cnt      <= 3'd0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            bus.locked    <= 1'b0;
            bus.bit_err   <= 1'b0;
            bus.sync_loss <= 1'b0;
            bus.err_cnt   <= '0;
        end else begin
            bus.bit_err   <= 1'b0;
            bus.sync_loss <= 1'b0;
            if (bus.clr_cnt) begin
                bus.err_cnt <= '0;
            end
            if (bus.din_valid) begin
                case (state)
                    ST_FILL: begin
                        r        <= r_fill;
                        fill_cnt <= fill_nxt;
                        // an all-zero window is the LFSR lock-up state, keep sliding
                        if (fill_nxt == 3'd4 && r_fill != 4'd0) begin
                            state    <= ST_VERIFY;
                            good_cnt <= '0;
                        end
                    end
                    ST_VERIFY: begin
                        r <= r_fly;
                        if (match) begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GOOD_W'(LOCK_LEN - 1)) begin
                                state      <= ST_LOCKED;
                                bus.locked <= 1'b1;
                                bad_cnt    <= '0;
                            end
                        end else begin
                            state    <= ST_FILL;
                            fill_cnt <= 3'd0;
                            good_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // flywheel: received bits never feed back into the state
                        r <= r_fly;
                        if (match) begin
                            bad_cnt <= '0;
                        end else begin
                            bus.bit_err <= 1'b1;
                            if (!bus.clr_cnt) begin
                                bus.err_cnt <= err_inc;
                            end
                            if (bad_cnt == BAD_W'(LOSS_ERRS - 1)) begin
                                state         <= ST_FILL;
                                fill_cnt      <= 3'd0;
                                bad_cnt       <= '0;
                                bus.locked    <= 1'b0;
                                bus.sync_loss <= 1'b1;
                            end else begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_FILL;
                        fill_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: vector table, directed corner sequences and a random run
// against a queue-based reference model; two instances cover ERR_W=8 and ERR_W=2.
module tb_lfsr_checker;
    localparam int LOCK_LEN  = 8;
    localparam int LOSS_ERRS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_checker_if #(.ERR_W(8)) bus8 ();
    lfsr_checker_if #(.ERR_W(2)) bus2 ();

    assign bus2.din       = bus8.din;
    assign bus2.din_valid = bus8.din_valid;
    assign bus2.clr_cnt   = bus8.clr_cnt;

    lfsr_checker #(.LOCK_LEN(LOCK_LEN), .LOSS_ERRS(LOSS_ERRS), .ERR_W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    lfsr_checker #(.LOCK_LEN(LOCK_LEN), .LOSS_ERRS(LOSS_ERRS), .ERR_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int checks = 0;
    int errors = 0;

    // generator stream from seed 4'b0001
    bit pat[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int gi = 0;

    function automatic bit gen_bit();
        bit b;
        b  = pat[gi % 5];
        gi = gi + 1;
        return b;
    endfunction

    // reference model: 0 = acquiring, 1 = verifying, 2 = locked
    int m_mode = 0;
    bit win[$];
    int good_n = 0;
    int bad_n  = 0;
    int err8   = 0;
    int err2   = 0;
    bit m_locked = 0, m_bit_err = 0, m_sync_loss = 0;

    task automatic model_step(input bit r, input bit v, input bit d, input bit c);
        bit exp_bit;
        if (r) begin
            m_mode = 0; win.delete(); good_n = 0; bad_n = 0;
            err8 = 0; err2 = 0; m_locked = 0; m_bit_err = 0; m_sync_loss = 0;
            return;
        end
        m_bit_err   = 0;
        m_sync_loss = 0;
        if (c) begin
            err8 = 0;
            err2 = 0;
        end
        if (!v) return;
        if (m_mode == 0) begin
            win.push_back(d);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4 && (win[0] || win[1] || win[2] || win[3])) begin
                m_mode = 1;
                good_n = 0;
            end
        end else begin
            // next expected bit is the parity of the last four sequence bits
            exp_bit = win[0] ^ win[1] ^ win[2] ^ win[3];
            win.push_back(exp_bit);
            void'(win.pop_front());
            if (m_mode == 1) begin
                if (d == exp_bit) begin
                    good_n++;
                    if (good_n == LOCK_LEN) begin
                        m_mode = 2; m_locked = 1; bad_n = 0;
                    end
                end else begin
                    m_mode = 0; win.delete(); good_n = 0;
                end
            end else if (d == exp_bit) begin
                bad_n = 0;
            end else begin
                m_bit_err = 1;
                if (!c) begin
                    if (err8 < 255) err8++;
                    if (err2 < 3) err2++;
                end
                bad_n++;
                if (bad_n == LOSS_ERRS) begin
                    m_mode = 0; win.delete(); bad_n = 0;
                    m_locked = 0; m_sync_loss = 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit d, input bit c);
        rst            = r;
        bus8.din_valid = v;
        bus8.din       = d;
        bus8.clr_cnt   = c;
        @(posedge clk);
        model_step(r, v, d, c);
        #1;
        check("locked",     bus8.locked,    m_locked);
        check("bit_err",    bus8.bit_err,   m_bit_err);
        check("sync_loss",  bus8.sync_loss, m_sync_loss);
        check("err_cnt",    bus8.err_cnt,   err8);
        check("err_cnt_w2", bus2.err_cnt,   err2);
        check("locked_w2",  bus2.locked,    m_locked);
    endtask

    task automatic wait_lock(input string name);
        int n = 0;
        for (int k = 0; k < 60 && !bus8.locked; k++) begin
            step(0, 1, gen_bit(), 0);
            n++;
        end
        check(name, n, 12);
    endtask

    typedef struct {
        bit rst;
        bit vld;
        bit din;
        bit clr;
        bit e_locked;
        bit e_bit_err;
        bit e_sync_loss;
        int e_err;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int n;
        int nerr;
        int burst;
        bit v, d, c, r;

        // reset, 12 clean bits to lock, one error, idle, clear
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 1; i <= 12; i++)
            tbl[i] = '{0, 1, pat[(i - 1) % 5], 0, (i == 12), 0, 0, 0};
        tbl[13] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[14] = '{0, 1, 0, 0, 1, 0, 0, 1};
        tbl[15] = '{0, 0, 1, 0, 1, 0, 0, 1};
        tbl[16] = '{0, 0, 0, 1, 1, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].clr);
            check("tbl_locked",    bus8.locked,    tbl[i].e_locked);
            check("tbl_bit_err",   bus8.bit_err,   tbl[i].e_bit_err);
            check("tbl_sync_loss", bus8.sync_loss, tbl[i].e_sync_loss);
            check("tbl_err_cnt",   bus8.err_cnt,   tbl[i].e_err);
        end
        gi = 14;

        // four consecutive errors while locked force resync
        nerr = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, ~gen_bit(), 0);
            nerr += int'(bus8.bit_err);
            if (k < 3) check("burst_no_early_loss", bus8.sync_loss, 0);
        end
        check("burst_sync_loss", bus8.sync_loss, 1);
        check("burst_unlocked",  bus8.locked, 0);
        check("burst_pulses",    nerr, 4);
        check("burst_err8",      bus8.err_cnt, 4);
        check("burst_err2_sat",  bus2.err_cnt, 3);
        wait_lock("relock_after_loss");

        // five isolated errors: ERR_W=2 saturates at 3
        step(0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, ~gen_bit(), 0);
            step(0, 1, gen_bit(), 0);
            step(0, 1, gen_bit(), 0);
        end
        check("iso_err8",   bus8.err_cnt, 5);
        check("iso_err2",   bus2.err_cnt, 3);
        check("iso_locked", bus8.locked, 1);

        // clear coinciding with an error wins, pulse still fires
        step(0, 1, ~gen_bit(), 1);
        check("clr_err_pulse", bus8.bit_err, 1);
        check("clr_err_cnt",   bus8.err_cnt, 0);
        step(0, 1, gen_bit(), 0);

        // constant zero never leaves acquisition
        step(1, 0, 0, 0);
        for (int k = 0; k < 50; k++) step(0, 1, 0, 0);
        check("zeros_locked", bus8.locked, 0);
        check("zeros_err",    bus8.err_cnt, 0);

        // mismatch on the fifth verify bit restarts acquisition silently
        step(1, 0, 0, 0);
        gi = 0;
        for (int k = 0; k < 8; k++) step(0, 1, gen_bit(), 0);
        step(0, 1, ~gen_bit(), 0);
        check("verify_miss_no_err", bus8.bit_err, 0);
        check("verify_miss_cnt",    bus8.err_cnt, 0);
        wait_lock("relock_after_verify_miss");

        // gaps between valid bits do not matter
        step(1, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 80 && !bus8.locked; k++) begin
            if (k % 2 == 0) begin
                step(0, 1, gen_bit(), 0);
                n++;
            end else begin
                step(0, 0, 1'($urandom_range(0, 1)), 0);
            end
        end
        check("gapped_lock_bits", n, 12);

        // reset while locked
        step(0, 1, ~gen_bit(), 0);
        step(1, 1, ~gen_bit(), 0);
        check("rst_locked",    bus8.locked, 0);
        check("rst_err",       bus8.err_cnt, 0);
        check("rst_bit_err",   bus8.bit_err, 0);
        check("rst_sync_loss", bus8.sync_loss, 0);
        wait_lock("relock_after_rst");

        // random traffic against the model
        burst = 0;
        for (int k = 0; k < 4000; k++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 1499) == 0);
            if (v) begin
                if ($urandom_range(0, 299) == 0) gi++;
                if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(2, 5);
                d = gen_bit();
                if (burst > 0) begin
                    d = ~d;
                    burst--;
                end else if ($urandom_range(0, 24) == 0) begin
                    d = ~d;
                end
            end else begin
                d = 1'($urandom_range(0, 1));
            end
            step(r, v, d, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
